// File: rtl/relu_share_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : relu_share_sched_if
//  Purpose  : Bundles the requester handshakes and the shared ReLU unit link
//             of the activation scheduler.
//  Signals  : req/req_data/req_ack        requester -> scheduler capture
//             resp_valid/resp_ready/
//             resp_data/resp_err          scheduler -> requester result
//             relu_valid_in/relu_input_data,
//             relu_output_data/relu_valid_out/relu_ready_out
//                                         scheduler <-> activation unit
//  Modports : slave  = scheduler side, master = requesters + activation unit
//  Revision : 1.0  initial release
// ============================================================================
interface relu_share_sched_if #(
    parameter int N_REQ = 4,
    parameter int LANES = 64,
    parameter int DW    = 16
);
    // Elements are two's-complement; the scheduler only moves them around.
    logic [N_REQ-1:0]                   req;
    logic [N_REQ-1:0][LANES-1:0][DW-1:0] req_data;
    logic [N_REQ-1:0]                   req_ack;
    logic [N_REQ-1:0]                   resp_valid;
    logic [N_REQ-1:0]                   resp_ready;
    logic [LANES-1:0][DW-1:0]           resp_data;
    logic                               resp_err;
    logic                               relu_valid_in;
    logic [LANES-1:0][DW-1:0]           relu_input_data;
    logic [LANES-1:0][DW-1:0]           relu_output_data;
    logic                               relu_valid_out;
    logic                               relu_ready_out;

    modport slave (
        input  req, req_data, resp_ready,
        input  relu_output_data, relu_valid_out, relu_ready_out,
        output req_ack, resp_valid, resp_data, resp_err,
        output relu_valid_in, relu_input_data
    );

    modport master (
        output req, req_data, resp_ready,
        output relu_output_data, relu_valid_out, relu_ready_out,
        input  req_ack, resp_valid, resp_data, resp_err,
        input  relu_valid_in, relu_input_data
    );
endinterface
`default_nettype wire

// File: rtl/relu_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : relu_share_sched
//  Purpose  : Round-robin scheduler time-sharing one LANES-wide ReLU unit
//             among N_REQ requesters. Captures the granted vector, pulses
//             relu_valid_in, waits (bounded by TIMEOUT) for relu_valid_out and
//             returns the result over a valid/ready response.
//  Ports    : clk    system clock, rising edge
//             reset  synchronous, active-high
//             sif    relu_share_sched_if.slave (requesters + activation unit)
//  Revision : 1.0  initial release
// ============================================================================
module relu_share_sched #(
    parameter int N_REQ   = 4,
    parameter int LANES   = 64,
    parameter int DW      = 16,
    parameter int TIMEOUT = 256
) (
    input  wire logic          clk,
    input  wire logic          reset,
    relu_share_sched_if.slave  sif
);
    localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0]  c_TO_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_IW-1:0]  c_LAST_IDX = c_IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_ONE = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                   r_state;
    logic [c_IW-1:0]          r_rr_ptr;
    logic [c_IW-1:0]          r_gnt_idx;
    logic [c_CW-1:0]          r_wait_cnt;
    logic [N_REQ-1:0]         r_req_ack;
    logic [N_REQ-1:0]         r_resp_valid;
    logic                     r_resp_err;
    logic                     r_relu_valid_in;
    logic [LANES-1:0][DW-1:0] r_relu_input_data;
    logic [LANES-1:0][DW-1:0] r_resp_data;

    // Round-robin pick: walk candidates from the highest offset down so the
    // last hit kept is the one closest to r_rr_ptr.
    int                       w_idx;
    logic [c_IW-1:0]          w_cand;
    logic [c_IW-1:0]          w_pick;
    logic                     w_any;

    always_comb begin
        w_idx  = 0;
        w_cand = '0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx  = (int'(r_rr_ptr) + k) % N_REQ;
            w_cand = c_IW'(w_idx);
            if (sif.req[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_rr_ptr          <= '0;
            r_gnt_idx         <= '0;
            r_wait_cnt        <= '0;
            r_req_ack         <= '0;
            r_resp_valid      <= '0;
            r_resp_err        <= 1'b0;
            r_relu_valid_in   <= 1'b0;
            r_relu_input_data <= '0;
            r_resp_data       <= '0;
        end else begin
            // Ack and start are single-cycle pulses, high only while in ISSUE.
            r_req_ack       <= '0;
            r_relu_valid_in <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any && sif.relu_ready_out) begin
                        r_gnt_idx         <= w_pick;
                        r_relu_input_data <= sif.req_data[w_pick];
                        r_req_ack         <= c_ONE << w_pick;
                        r_relu_valid_in   <= 1'b1;
                        r_state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rr_ptr   <= (r_gnt_idx == c_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // A result arriving on the final count still wins over the abort.
                    if (sif.relu_valid_out) begin
                        r_resp_data  <= sif.relu_output_data;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= c_ONE << r_gnt_idx;
                        r_state      <= S_RESP;
                    end else if (r_wait_cnt == c_TO_LAST) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= c_ONE << r_gnt_idx;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (sif.resp_ready[r_gnt_idx]) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sif.req_ack         = r_req_ack;
    assign sif.resp_valid      = r_resp_valid;
    assign sif.resp_data       = r_resp_data;
    assign sif.resp_err        = r_resp_err;
    assign sif.relu_valid_in   = r_relu_valid_in;
    assign sif.relu_input_data = r_relu_input_data;
endmodule
`default_nettype wire

// File: tb/tb_relu_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_relu_share_sched
//  Purpose  : Directed scoreboard bench for relu_share_sched with a 1-cycle
//             ReLU unit model and per-requester hold-until-ack drivers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_share_sched;
    localparam int N  = 4;
    localparam int L  = 64;
    localparam int W  = 16;
    localparam int TO = 16;

    typedef logic [L-1:0][W-1:0] vec_t;
    typedef struct { int idx; vec_t v; } ack_t;
    typedef struct { int idx; logic err; vec_t d; } rsp_t;

    localparam vec_t C_FORCE = {L{16'h0101}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    relu_share_sched_if #(.N_REQ(N), .LANES(L), .DW(W)) bus ();

    relu_share_sched #(.N_REQ(N), .LANES(L), .DW(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (bus)
    );

    logic [N-1:0]              req_v    = '0;
    logic [N-1:0][L-1:0][W-1:0] rd_v    = '0;
    logic [N-1:0]              rdy_v    = '1;
    logic                      rout_v   = 1'b1;
    logic                      unit_en  = 1'b1;
    logic                      force_vo = 1'b0;
    logic                      model_vo = 1'b0;
    vec_t                      model_d  = '0;

    assign bus.req              = req_v;
    assign bus.req_data         = rd_v;
    assign bus.resp_ready       = rdy_v;
    assign bus.relu_ready_out   = rout_v;
    assign bus.relu_valid_out   = model_vo | force_vo;
    assign bus.relu_output_data = force_vo ? C_FORCE : model_d;

    int   n_vec = 0;
    int   n_err = 0;
    ack_t ackq[$];
    rsp_t sbq[$];
    ack_t pq[$];
    ack_t ea;
    rsp_t er;
    int   drv_hit;
    logic [N-1:0] prev_ack = '0;

    function automatic vec_t relu_vec(vec_t v);
        vec_t r;
        for (int l = 0; l < L; l++) r[l] = v[l][W-1] ? '0 : v[l];
        return r;
    endfunction

    function automatic vec_t mkvec(int s);
        vec_t r;
        for (int l = 0; l < L; l++) r[l] = W'(((s * 977 + l * 613) % 3001) - 1500);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
        int fl;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            fl = 0;
            for (int k = L - 1; k >= 0; k--) if (act[k] !== exp[k]) fl = k;
            $display("FAIL %s: lane %0d got %0d expected %0d (t=%0t)", nm, fl,
                     $signed(act[fl]), $signed(exp[fl]), $time);
        end
    endtask

    // Unit model: ReLU with one cycle of latency.
    always @(posedge clk) begin
        model_vo <= unit_en && bus.relu_valid_in;
        if (unit_en && bus.relu_valid_in) model_d <= relu_vec(bus.relu_input_data);
    end

    // Requesters: hold req until acked, then take the next queued vector.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req_v[i] && bus.req_ack[i]) req_v[i] = 1'b0;
            if (!req_v[i]) begin
                drv_hit = -1;
                for (int k = pq.size() - 1; k >= 0; k--) if (pq[k].idx == i) drv_hit = k;
                if (drv_hit >= 0) begin
                    rd_v[i]  = pq[drv_hit].v;
                    req_v[i] = 1'b1;
                    pq.delete(drv_hit);
                end
            end
        end
    end

    // Grant monitor.
    always @(negedge clk) begin
        if (!reset && (bus.relu_valid_in || bus.req_ack != '0)) begin
            if (ackq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_grant: ack=%b valid_in=%b, none expected", bus.req_ack, bus.relu_valid_in);
            end else begin
                ea = ackq.pop_front();
                chk("req_ack", 64'(bus.req_ack), 64'(1) << ea.idx);
                chk("relu_valid_in", 64'(bus.relu_valid_in), 64'd1);
                chk("ack_single_cycle", 64'(prev_ack), 64'd0);
                chk_vec("relu_input_data", bus.relu_input_data, ea.v);
            end
        end
        prev_ack = bus.req_ack;
    end

    // Response monitor: compare on each handshake.
    always @(negedge clk) begin
        if (!reset && (bus.resp_valid & bus.resp_ready) != '0) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: resp_valid=%b, none expected", bus.resp_valid);
            end else begin
                er = sbq.pop_front();
                chk("resp_valid", 64'(bus.resp_valid), 64'(1) << er.idx);
                chk("resp_err", 64'(bus.resp_err), 64'(er.err));
                chk_vec("resp_data", bus.resp_data, er.d);
            end
        end
    end

    task automatic post(input int i, input vec_t v);
        pq.push_back('{idx: i, v: v});
    endtask

    task automatic exp_ack(input int i, input vec_t v);
        ackq.push_back('{idx: i, v: v});
    endtask

    task automatic exp_rsp(input int i, input logic e, input vec_t d);
        sbq.push_back('{idx: i, err: e, d: d});
    endtask

    task automatic txn(input int i, input vec_t v);
        post(i, v);
        exp_ack(i, v);
        exp_rsp(i, 1'b0, relu_vec(v));
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sbq.size() != 0 || ackq.size() != 0 || pq.size() != 0 || req_v != '0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (sbq.size() != 0 || ackq.size() != 0 || pq.size() != 0 || req_v != '0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: pending resp=%0d ack=%0d post=%0d req=%b, required all empty",
                     sbq.size(), ackq.size(), pq.size(), req_v);
            sbq.delete();
            ackq.delete();
            pq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ack(input int i, input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.req_ack[i] && c < budget);
        if (!bus.req_ack[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ack%0d: no ack within %0d cycles, required one", i, budget);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ack"}, 64'(bus.req_ack), 64'd0);
        chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_resp_err"}, 64'(bus.resp_err), 64'd0);
        chk({tag, "_relu_valid_in"}, 64'(bus.relu_valid_in), 64'd0);
        chk_vec({tag, "_relu_input_data"}, bus.relu_input_data, '0);
        chk_vec({tag, "_resp_data"}, bus.resp_data, '0);
    endtask

    initial begin
        vec_t v1, e1, va, vb;
        int   c;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Test 1: single request, hand-computed lanes.
        v1 = '0;
        v1[0]  = 16'(-2342);
        v1[1]  = 16'd3540;
        v1[63] = 16'(-4295);
        e1 = '0;
        e1[1] = 16'd3540;
        post(0, v1);
        exp_ack(0, v1);
        exp_rsp(0, 1'b0, e1);
        drain(100);

        // Test 2: all four request from rr_ptr=0 -> order 0,1,2,3,0.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(0, mkvec(1));
        txn(1, mkvec(2));
        txn(2, mkvec(3));
        txn(3, mkvec(4));
        txn(0, mkvec(5));
        drain(200);

        // Test 3: serve req1 (rr_ptr -> 2), then req0+req1 -> 0 then 1.
        txn(1, mkvec(6));
        drain(100);
        txn(0, mkvec(7));
        txn(1, mkvec(8));
        drain(100);

        // Test 4: unit silent -> timeout error response, then normal service.
        unit_en = 1'b0;
        va = mkvec(9);
        post(0, va);
        exp_ack(0, va);
        exp_rsp(0, 1'b1, '0);
        wait_ack(0, 50);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.resp_valid == '0 && c < 40);
        chk("timeout_latency", 64'(c), 64'd17);
        drain(100);
        unit_en = 1'b1;
        txn(3, mkvec(10));
        drain(100);

        // Test 5: requester 1 stalls its response for 10 cycles; req2 waits.
        rdy_v[1] = 1'b0;
        va = mkvec(11);
        vb = mkvec(12);
        txn(1, va);
        wait_ack(1, 50);
        txn(2, vb);
        c = 0;
        while (!bus.resp_valid[1] && c < 50) begin
            @(negedge clk);
            c++;
        end
        for (int j = 0; j < 10; j++) begin
            chk("stall_resp_valid", 64'(bus.resp_valid), 64'b0010);
            chk_vec("stall_resp_data", bus.resp_data, relu_vec(va));
            chk("stall_no_issue", 64'(bus.relu_valid_in), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rdy_v[1] = 1'b1;
        drain(100);

        // Test 6: reset in WAIT with a late valid_out; relu_ready_out=0 blocks grants.
        unit_en = 1'b0;
        va = mkvec(13);
        post(0, va);
        exp_ack(0, va);
        wait_ack(0, 50);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        rout_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        va = mkvec(14);
        vb = mkvec(15);
        post(3, vb);
        post(0, va);
        for (int j = 0; j < 6; j++) begin
            chk_idle_outputs("post_reset");
            force_vo = (j == 0);
            @(negedge clk);
        end
        unit_en = 1'b1;
        exp_ack(0, va);
        exp_rsp(0, 1'b0, relu_vec(va));
        exp_ack(3, vb);
        exp_rsp(3, 1'b0, relu_vec(vb));
        rout_v = 1'b1;
        drain(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
